// File: rtl/buck_pkg.sv
// Shared state and fault-code encodings for the buck converter sequencer.
package buck_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SOFT_START = 3'd1,
        ST_REGULATE   = 3'd2,
        ST_COOLDOWN   = 3'd3,
        ST_LOCKOUT    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE = 2'b00,
        FC_OV   = 2'b01,
        FC_UV   = 2'b10
    } fcode_t;

    // States in which the PWM path is live and the PID runs.
    function automatic logic is_running(input state_t s);
        return (s == ST_SOFT_START) || (s == ST_REGULATE);
    endfunction

endpackage

// File: rtl/buck_fault_filter.sv
// Threshold compare plus consecutive-bad-sample counter; one instance per fault direction.
module buck_fault_filter #(
    parameter logic [11:0] LIMIT     = 12'd3000,
    parameter logic [3:0]  FAULT_CNT = 4'd4,
    parameter bit          IS_OV     = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic        valid_i,
    input  logic [11:0] sample_i,
    output logic        bad_o,
    output logic        trip_o
);

    logic [3:0] cnt_q, cnt_d;

    assign bad_o = IS_OV ? (sample_i > LIMIT) : (sample_i < LIMIT);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !en_i) begin
            cnt_d = '0;
        end else if (valid_i) begin
            if (!bad_o)
                cnt_d = '0;
            else if (cnt_q != 4'hF)
                cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // Trip on the sample that makes the run reach FAULT_CNT, so the FSM moves on that same edge.
    assign trip_o = en_i && valid_i && bad_o && (({1'b0, cnt_q} + 5'd1) >= {1'b0, FAULT_CNT});

endmodule

// File: rtl/buck_sequencer.sv
// Buck converter sequencer: soft-start ramp, OV/UV supervision, timed retry and lockout.
module buck_sequencer
    import buck_pkg::*;
#(
    parameter logic [11:0] V_REF        = 12'd2048,
    parameter logic [11:0] RAMP_STEP    = 12'd16,
    parameter logic [15:0] RAMP_DIV     = 16'd1000,
    parameter logic [11:0] OV_LIMIT     = 12'd3000,
    parameter logic [11:0] UV_LIMIT     = 12'd1024,
    parameter logic [3:0]  FAULT_CNT    = 4'd4,
    parameter logic [23:0] RETRY_CYCLES = 24'd1_000_000,
    parameter logic [2:0]  MAX_RETRY    = 3'd3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [11:0] voltage_fb,
    input  logic        fb_valid,
    input  logic [9:0]  duty_in,
    output logic [11:0] setpoint,
    output logic        pid_hold,
    output logic [9:0]  duty_out,
    output logic        power_good,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [2:0]  state_mon
);

    state_t      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [23:0] tmr_q, tmr_d;
    logic [2:0]  retry_q, retry_d;
    logic [11:0] sp_q, sp_d;
    logic [9:0]  duty_q;
    logic        pg_q, pg_d;
    fcode_t      fc_q, fc_d;

    logic        run, tick, expired, clr;
    logic        ov_bad, ov_trip, uv_bad, uv_trip;
    logic [12:0] sp_sum;

    assign run     = is_running(state_q);
    assign clr     = !enable;
    assign tick    = (state_q == ST_SOFT_START) && (div_q == RAMP_DIV - 16'd1);
    assign expired = (state_q == ST_COOLDOWN) && (tmr_q == RETRY_CYCLES - 24'd1);
    assign sp_sum  = {1'b0, sp_q} + {1'b0, RAMP_STEP};

    buck_fault_filter #(.LIMIT(OV_LIMIT), .FAULT_CNT(FAULT_CNT), .IS_OV(1'b1)) u_ov (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .en_i(run), .valid_i(fb_valid),
        .sample_i(voltage_fb), .bad_o(ov_bad), .trip_o(ov_trip)
    );

    // UV is only meaningful once the output has been brought up.
    buck_fault_filter #(.LIMIT(UV_LIMIT), .FAULT_CNT(FAULT_CNT), .IS_OV(1'b0)) u_uv (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .en_i(state_q == ST_REGULATE), .valid_i(fb_valid),
        .sample_i(voltage_fb), .bad_o(uv_bad), .trip_o(uv_trip)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:       state_d = ST_SOFT_START;
                ST_SOFT_START: if (ov_trip) state_d = ST_COOLDOWN;
                               else if (sp_q == V_REF) state_d = ST_REGULATE;
                ST_REGULATE:   if (ov_trip || uv_trip) state_d = ST_COOLDOWN;
                ST_COOLDOWN:   if (expired) state_d = (retry_q < MAX_RETRY) ? ST_SOFT_START : ST_LOCKOUT;
                ST_LOCKOUT:    state_d = ST_LOCKOUT;
                default:       state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        pid_hold   = !run;
        duty_out   = run ? duty_q : '0;
        fault      = (state_q == ST_COOLDOWN) || (state_q == ST_LOCKOUT);
        setpoint   = sp_q;
        power_good = pg_q;
        fault_code = fc_q;
        state_mon  = state_q;
    end

    always_comb begin
        div_d = '0;
        if (state_q == ST_SOFT_START && state_d == ST_SOFT_START)
            div_d = tick ? '0 : ((div_q == '1) ? div_q : div_q + 16'd1);

        tmr_d = '0;
        if (state_q == ST_COOLDOWN && state_d == ST_COOLDOWN)
            tmr_d = (tmr_q == '1) ? tmr_q : tmr_q + 24'd1;

        retry_d = retry_q;
        if (state_d == ST_IDLE)
            retry_d = '0;
        else if (expired && state_d == ST_SOFT_START && retry_q != '1)
            retry_d = retry_q + 3'd1;

        sp_d = sp_q;
        if (!is_running(state_d))
            sp_d = '0;
        else if (tick && state_d == ST_SOFT_START)
            sp_d = (sp_sum >= {1'b0, V_REF}) ? V_REF : sp_sum[11:0];

        // Code survives the retry ramp so software can see why the restart happened.
        fc_d = fc_q;
        if (state_d == ST_IDLE)
            fc_d = FC_NONE;
        else if (state_d == ST_REGULATE && state_q != ST_REGULATE)
            fc_d = FC_NONE;
        else if (state_d == ST_COOLDOWN && state_q != ST_COOLDOWN)
            fc_d = ov_trip ? FC_OV : FC_UV;

        pg_d = pg_q;
        if (state_d != ST_REGULATE)
            pg_d = 1'b0;
        else if (fb_valid && state_q == ST_REGULATE)
            pg_d = !ov_bad && !uv_bad;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q   <= '0;
            tmr_q   <= '0;
            retry_q <= '0;
            sp_q    <= '0;
            duty_q  <= '0;
            pg_q    <= 1'b0;
            fc_q    <= FC_NONE;
        end else begin
            div_q   <= div_d;
            tmr_q   <= tmr_d;
            retry_q <= retry_d;
            sp_q    <= sp_d;
            duty_q  <= duty_in;
            pg_q    <= pg_d;
            fc_q    <= fc_d;
        end
    end

endmodule

// File: tb/tb_buck_sequencer.sv
// Directed table-driven bench for buck_sequencer with small ramp/retry parameters.
module tb_buck_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, enable, fb_valid;
    logic [11:0] voltage_fb;
    logic [9:0]  duty_in;
    logic [11:0] setpoint;
    logic        pid_hold;
    logic [9:0]  duty_out;
    logic        power_good, fault;
    logic [1:0]  fault_code;
    logic [2:0]  state_mon;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    buck_sequencer #(
        .V_REF(12'd2048), .RAMP_STEP(12'd512), .RAMP_DIV(16'd4),
        .OV_LIMIT(12'd3000), .UV_LIMIT(12'd1024), .FAULT_CNT(4'd4),
        .RETRY_CYCLES(24'd10), .MAX_RETRY(3'd2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .voltage_fb(voltage_fb),
        .fb_valid(fb_valid), .duty_in(duty_in), .setpoint(setpoint),
        .pid_hold(pid_hold), .duty_out(duty_out), .power_good(power_good),
        .fault(fault), .fault_code(fault_code), .state_mon(state_mon)
    );

    typedef struct {
        int en; int vld; int vfb; int duty; int ncyc;
        int st; int sp; int du; int pg; int flt; int fc;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int st, input int sp, input int du,
                           input int pg, input int flt, input int fc);
        chk({tag, ".state"}, int'(state_mon), st);
        chk({tag, ".setpoint"}, int'(setpoint), sp);
        chk({tag, ".duty_out"}, int'(duty_out), du);
        chk({tag, ".power_good"}, int'(power_good), pg);
        chk({tag, ".fault"}, int'(fault), flt);
        chk({tag, ".fault_code"}, int'(fault_code), fc);
        chk({tag, ".pid_hold"}, int'(pid_hold), (st == 1 || st == 2) ? 0 : 1);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; fb_valid = 1'b0; voltage_fb = '0; duty_in = 10'd55;
        step(2);
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        step(1);
        chk("idle_hold.state", int'(state_mon), 0);

        //        en vld vfb  duty n   st sp   du  pg flt fc
        tbl.push_back('{1, 0, 0,    100, 1,  1, 0,    100, 0, 0, 0});
        tbl.push_back('{1, 0, 0,    101, 4,  1, 512,  101, 0, 0, 0});
        tbl.push_back('{1, 0, 0,    102, 3,  1, 512,  102, 0, 0, 0});
        tbl.push_back('{1, 0, 0,    103, 1,  1, 1024, 103, 0, 0, 0});
        tbl.push_back('{1, 0, 0,    104, 4,  1, 1536, 104, 0, 0, 0});
        tbl.push_back('{1, 0, 0,    105, 4,  1, 2048, 105, 0, 0, 0});
        tbl.push_back('{1, 0, 0,    106, 1,  2, 2048, 106, 0, 0, 0});
        tbl.push_back('{1, 1, 2000, 107, 1,  2, 2048, 107, 1, 0, 0});
        tbl.push_back('{1, 1, 900,  108, 3,  2, 2048, 108, 0, 0, 0});
        tbl.push_back('{1, 1, 2000, 109, 1,  2, 2048, 109, 1, 0, 0});
        tbl.push_back('{1, 1, 900,  110, 3,  2, 2048, 110, 0, 0, 0});
        tbl.push_back('{1, 1, 2000, 111, 1,  2, 2048, 111, 1, 0, 0});
        tbl.push_back('{1, 1, 1024, 112, 4,  2, 2048, 112, 1, 0, 0});
        tbl.push_back('{1, 1, 3000, 113, 4,  2, 2048, 113, 1, 0, 0});
        tbl.push_back('{1, 1, 3100, 114, 3,  2, 2048, 114, 0, 0, 0});
        tbl.push_back('{1, 0, 3100, 115, 2,  2, 2048, 115, 0, 0, 0});
        tbl.push_back('{1, 1, 3100, 116, 1,  3, 0,    0,   0, 1, 1});
        tbl.push_back('{1, 0, 0,    117, 9,  3, 0,    0,   0, 1, 1});
        tbl.push_back('{1, 0, 0,    118, 1,  1, 0,    118, 0, 0, 1});
        tbl.push_back('{1, 0, 0,    119, 16, 1, 2048, 119, 0, 0, 1});
        tbl.push_back('{1, 0, 0,    120, 1,  2, 2048, 120, 0, 0, 0});

        for (int i = 0; i < tbl.size(); i++) begin
            enable     = (tbl[i].en != 0);
            fb_valid   = (tbl[i].vld != 0);
            voltage_fb = 12'(tbl[i].vfb);
            duty_in    = 10'(tbl[i].duty);
            step(tbl[i].ncyc);
            chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].sp, tbl[i].du,
                    tbl[i].pg, tbl[i].flt, tbl[i].fc);
        end
        fb_valid = 1'b0;

        // duty path has exactly one clock of latency
        duty_in = 10'd300;
        #1;
        chk("duty_lat.before", int'(duty_out), 120);
        step(1);
        chk("duty_lat.after", int'(duty_out), 300);

        // enable drop beats a simultaneous 4th OV sample
        fb_valid = 1'b1; voltage_fb = 12'd3100;
        step(3);
        chk("prio.pre", int'(state_mon), 2);
        enable = 1'b0;
        step(1);
        chk_all("prio", 0, 0, 0, 0, 0, 0);
        fb_valid = 1'b0; enable = 1'b1;
        step(18);
        chk("prio.rerun", int'(state_mon), 2);
        fb_valid = 1'b1;
        step(3);
        chk("prio.cnt_cleared", int'(state_mon), 2);
        fb_valid = 1'b0;

        // three UV trips exhaust the retries
        for (int k = 0; k < 3; k++) begin
            fb_valid = 1'b1; voltage_fb = 12'd900;
            step(4);
            fb_valid = 1'b0;
            chk_all($sformatf("uv%0d.trip", k), 3, 0, 0, 0, 1, 2);
            step(10);
            if (k < 2) begin
                chk_all($sformatf("uv%0d.retry", k), 1, 0, 300, 0, 0, 2);
                step(17);
                chk($sformatf("uv%0d.reg", k), int'(state_mon), 2);
            end else begin
                chk_all("lockout", 4, 0, 0, 0, 1, 2);
            end
        end
        step(5);
        chk_all("lockout.hold", 4, 0, 0, 0, 1, 2);
        enable = 1'b0;
        step(1);
        chk_all("lockout.exit", 0, 0, 0, 0, 0, 0);

        // UV ignored during ramp, then reset mid-ramp
        enable = 1'b1;
        step(1);
        chk("ramp.ss", int'(state_mon), 1);
        fb_valid = 1'b1; voltage_fb = 12'd900;
        step(8);
        chk_all("ramp.uv_ignored", 1, 1024, 300, 0, 0, 0);
        fb_valid = 1'b0;
        rst_n = 1'b0;
        step(1);
        chk_all("midreset", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        step(1);
        chk_all("post_reset.ss", 1, 0, 300, 0, 0, 0);
        step(4);
        chk("post_reset.sp", int'(setpoint), 512);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/buck_sequencer.md
BUCK_SEQUENCER -- requirements
Module: buck_sequencer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- V_REF, 12'd2048, final regulation setpoint.
- RAMP_STEP, 12'd16, setpoint increment per ramp tick.
- RAMP_DIV, 16'd1000, clocks per ramp tick.
- OV_LIMIT, 12'd3000, overvoltage threshold (strictly greater trips).
- UV_LIMIT, 12'd1024, undervoltage threshold (strictly less trips).
- FAULT_CNT, 4'd4, consecutive bad samples needed to trip.
- RETRY_CYCLES, 24'd1_000_000, cooldown length in clocks.
- MAX_RETRY, 3'd3, automatic restarts before lockout.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock.
- rst_n, in, 1, synchronous active-low reset.
- enable, in, 1, converter run request (level).
- voltage_fb, in, 12, sampled output voltage.
- fb_valid, in, 1, one-cycle strobe qualifying voltage_fb.
- duty_in, in, 10, PID duty request.
- setpoint, out, 12, setpoint to the PID.
- pid_hold, out, 1, PID integrator clear/hold.
- duty_out, out, 10, gated duty to the PWM generator.
- power_good, out, 1, output in regulation window.
- fault, out, 1, fault active.
- fault_code, out, 2, 00 none, 01 OV, 10 UV.
- state_mon, out, 3, current state encoding.

Function
REQ-003 The FSM SHALL have states IDLE=0, SOFT_START=1, REGULATE=2, COOLDOWN=3, LOCKOUT=4.
REQ-004 IDLE: setpoint=0, duty_out=0, pid_hold=1; enable=1 SHALL transition to SOFT_START next clock.
REQ-005 SOFT_START: the ramp divider counts RAMP_DIV clocks per tick. Each tick adds RAMP_STEP to setpoint, saturating at V_REF with no wrap. The clock after setpoint==V_REF SHALL enter REGULATE.
REQ-006 duty_out SHALL equal duty_in registered (1-clock latency) in SOFT_START and REGULATE, and 0 in all other states. pid_hold SHALL be 0 only in SOFT_START and REGULATE.
REQ-007 OV detection (SOFT_START, REGULATE):
- Each fb_valid with voltage_fb>OV_LIMIT increments the OV counter.
- Any fb_valid without OV clears it.
- Reaching FAULT_CNT SHALL enter COOLDOWN with fault_code=01.
REQ-008 UV detection (REGULATE only): same counting rule with voltage_fb<UV_LIMIT, entering COOLDOWN with fault_code=10. UV SHALL be ignored during SOFT_START.
REQ-009 COOLDOWN:
- fault=1, setpoint reset to 0, timer counts RETRY_CYCLES clocks.
- At expiry: if retry_cnt<MAX_RETRY, increment retry_cnt and enter SOFT_START; otherwise enter LOCKOUT.
REQ-010 LOCKOUT: fault=1, fault_code held, outputs as IDLE. Only enable=0 exits (to IDLE).
REQ-011 enable=0 in any state SHALL enter IDLE next clock, clearing retry_cnt, fault, fault_code, the bad-sample counters and the timers. It has priority over a simultaneous fault trip.
REQ-012 fault_code SHALL hold its value from the trip until the next IDLE entry or the first REGULATE entry. fault SHALL deassert on leaving COOLDOWN to SOFT_START.
REQ-013 power_good SHALL be 1 only in REGULATE when the last valid sample satisfied UV_LIMIT<=voltage_fb<=OV_LIMIT. It is registered, so it updates the clock after fb_valid.
REQ-014 fb_valid coinciding with a state change SHALL be evaluated against the pre-transition state.
REQ-015 All counters SHALL saturate rather than wrap.

Reset
REQ-016 With rst_n=0 at a clock edge, the block SHALL return to IDLE and drive:
- setpoint=0, duty_out=0, pid_hold=1, power_good=0, fault=0, fault_code=00, state_mon=0.
- All counters and timers cleared.
This applies from any state, including mid-ramp and COOLDOWN.

Structure
REQ-017 State encodings and fault_code values SHALL live in shared package buck_pkg.
REQ-018 Window comparison and consecutive-sample counting SHALL be one sub-module, buck_fault_filter, instantiated for OV and UV.

Verification (bench parameters: RAMP_DIV=4, RAMP_STEP=512, V_REF=2048, FAULT_CNT=4, RETRY_CYCLES=10, MAX_RETRY=2)
REQ-019 Soft start: enable=1 -> setpoint steps 0,512,1024,1536,2048 every 4 clocks, then state_mon=2 and duty_out follows duty_in with 1-clock delay.
REQ-020 OV trip and retry: in REGULATE, 4 valid samples at 3100 -> state_mon=3, fault=1, fault_code=01, duty_out=0. After 10 clocks -> SOFT_START, setpoint restarts at 0.
REQ-021 Filter reset: 3 samples at 900, 1 at 2000, 3 at 900 -> no trip, power_good toggles 0/1/0.
REQ-022 Lockout: three consecutive UV trips -> state_mon=4, fault_code=10. enable=0 -> IDLE with fault=0 next clock.
REQ-023 Priority: enable=0 on the same clock as the 4th OV sample -> IDLE, fault=0.
REQ-024 Reset mid-ramp: rst_n=0 at setpoint=1024 -> all outputs at the REQ-016 reset values on the next clock.
